// File: rtl/sar_conv_sequencer.sv
// Periodic SAR conversion sequencer: drives cnvst, captures results on eoc into a
// 4-entry FIFO, and flags timeouts and dropped samples with sticky error bits.
module sar_conv_sequencer #(
  parameter int PERIOD  = 32,
  parameter int TIMEOUT = 24,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       eoc,
  input  logic [9:0] sar,
  output logic       cnvst,
  output logic [9:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [2:0] fifo_count,
  output logic       overflow,
  output logic       timeout_err,
  input  logic       clr_err
);

  localparam int CW = $clog2(PERIOD);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
  localparam logic [2:0]    FULL    = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, CONV, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, timeout_evt;

  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            pop, wr_en, drop;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    push        = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (eoc) begin
          push    = 1'b1;
          state_d = GAP;
        end else if (cnt_q == CNT_TO) begin
          timeout_evt = 1'b1;
          state_d     = GAP;
        end
      end
      GAP: begin
        // A lingering eoc holds the gap open so a stale result is never re-captured.
        if (cnt_q == CNT_MAX && !eoc) begin
          if (enable) begin
            state_d = CONV;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnvst = (state_q == CONV);

  assign dout_valid = (fifo_count != 3'd0);
  assign pop        = dout_valid && dout_ready;
  assign wr_en      = push && ((fifo_count != FULL) || pop);
  assign drop       = push && (fifo_count == FULL) && !pop;
  assign dout       = mem[rd_ptr];

  // NOTE: the storage array is reset because dout must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= sar;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overflow    <= drop        | (overflow    & ~clr_err);
      timeout_err <= timeout_evt | (timeout_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Self-checking bench for sar_conv_sequencer: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the conversion schedule and FIFO.
module tb_sar_conv_sequencer;

  localparam int PERIOD  = 32;
  localparam int TIMEOUT = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, eoc, dout_ready, clr_err;
  logic [9:0] sar;
  logic       cnvst, dout_valid, overflow, timeout_err;
  logic [9:0] dout;
  logic [2:0] fifo_count;

  sar_conv_sequencer #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .eoc(eoc), .sar(sar),
    .cnvst(cnvst), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_count(fifo_count), .overflow(overflow), .timeout_err(timeout_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: running/converting flags, cycles since last start, result queue.
  bit         m_run, m_conv, m_ovf, m_to;
  int         m_age;
  logic [9:0] m_q[$];

  // Observation of cnvst waveform shape.
  int   cyc = 0;
  int   rise_q[$];
  int   high_run, last_high;
  logic prev_cnvst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_conv = 0; m_ovf = 0; m_to = 0; m_age = 0;
    m_q.delete();
    prev_cnvst = 1'b0; high_run = 0; last_high = 0;
  endfunction

  function automatic void model_edge(bit en, bit e, logic [9:0] s, bit rdy, bit clr);
    bit pop = (m_q.size() != 0) && rdy;
    bit cap = 0, to = 0, ov = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_conv = 1; m_age = 0; end
    end else if (m_conv) begin
      if (e) begin cap = 1; m_conv = 0; end
      else if (m_age == TIMEOUT - 1) begin to = 1; m_conv = 0; end
      m_age++;
    end else begin
      if (m_age >= PERIOD - 1 && !e) begin
        if (en) begin m_conv = 1; m_age = 0; end
        else m_run = 0;
      end else if (m_age < PERIOD - 1) m_age++;
    end
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() < 4) m_q.push_back(s);
      else ov = 1;
    end
    m_ovf = ov | (m_ovf & !clr);
    m_to  = to | (m_to & !clr);
  endfunction

  task automatic compare_all();
    check("cnvst", 32'(cnvst), 32'(m_conv));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("dout_valid", 32'(dout_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("dout", 32'(dout), 32'(m_q[0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  task automatic step(input bit en, input bit e, input logic [9:0] s, input bit rdy, input bit clr);
    @(negedge clk);
    enable = en; eoc = e; sar = s; dout_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_edge(en, e, s, rdy, clr);
    #1;
    compare_all();
    cyc++;
    if (cnvst && !prev_cnvst) rise_q.push_back(cyc);
    if (cnvst) high_run++;
    else if (prev_cnvst) begin last_high = high_run; high_run = 0; end
    prev_cnvst = cnvst;
  endtask

  // Wait for the next conversion, hold it dly cycles, then return eoc with sample s.
  task automatic conv(input bit en_after, input logic [9:0] s, input int dly, input bit rdy_cap);
    int n = 0;
    while (!cnvst && n < 64) begin step(1, 0, '0, 0, 0); n++; end
    check("conv_start", 32'(cnvst), 32'd1);
    repeat (dly) step(en_after, 0, '0, 0, 0);
    step(en_after, 1, s, rdy_cap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 0; eoc = 0; sar = '0; dout_ready = 0; clr_err = 0;
    model_reset();
    #12;
    check("rst_cnvst", 32'(cnvst), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Captured conversion: eoc on the 12th high cycle.
    rise_q.delete();
    step(1, 0, '0, 0, 0);
    check("first_start", 32'(cnvst), 32'd1);
    repeat (11) step(1, 0, '0, 0, 0);
    step(1, 1, 10'h2A5, 0, 0);
    check("cap_high_len", 32'(last_high), 32'd12);
    check("cap_count", 32'(fifo_count), 32'd1);
    check("cap_dout", 32'(dout), 32'h2A5);
    for (int i = 0; i < 40 && rise_q.size() < 2; i++) step(1, 0, '0, 0, 0);
    check("cap_rises", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() >= 2) check("cap_period", 32'(rise_q[1] - rise_q[0]), 32'd32);

    // Enable dropped mid-conversion: it still completes, then idles.
    repeat (3) step(0, 0, '0, 0, 0);
    step(0, 1, 10'h155, 0, 0);
    check("drop_en_high_len", 32'(last_high), 32'd4);
    check("drop_en_count", 32'(fifo_count), 32'd2);
    repeat (40) step(0, 0, '0, 0, 0);
    check("drop_en_no_restart", 32'(rise_q.size()), 32'd2);
    check("drop_en_idle", 32'(cnvst), 32'd0);
    check("drain_a", 32'(dout), 32'h2A5);
    step(0, 0, '0, 1, 0);
    check("drain_b", 32'(dout), 32'h155);
    step(0, 0, '0, 1, 0);
    check("drain_empty", 32'(fifo_count), 32'd0);

    // Timeout: eoc never arrives.
    rise_q.delete();
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 40 && rise_q.size() < 2; i++) step(1, 0, '0, 0, 0);
    check("to_high_len", 32'(last_high), 32'd24);
    check("to_flag", 32'(timeout_err), 32'd1);
    check("to_count", 32'(fifo_count), 32'd0);
    if (rise_q.size() >= 2) check("to_period", 32'(rise_q[1] - rise_q[0]), 32'd32);
    else check("to_rises", 32'(rise_q.size()), 32'd2);
    repeat (60) step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    check("to_clear", 32'(timeout_err), 32'd0);

    // Overflow: five results into a four-entry FIFO with no consumer.
    for (int k = 1; k <= 5; k++) conv(1, 10'(k), 2, 0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_drain", 32'(dout), 32'(k));
      step(0, 0, '0, 1, 0);
    end
    check("ovf_drained", 32'(fifo_count), 32'd0);
    repeat (40) step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the capture edge: push accepted, no overflow.
    for (int k = 11; k <= 14; k++) conv(1, 10'(k), 1, 0);
    conv(0, 10'd9, 1, 1);
    check("full_pop_count", 32'(fifo_count), 32'd4);
    check("full_pop_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check("full_pop_last", 32'(dout), 32'd9);
      step(0, 0, '0, 1, 0);
    end
    repeat (40) step(0, 0, '0, 0, 0);

    // Asynchronous reset mid-conversion.
    conv(1, 10'd21, 1, 0);
    conv(1, 10'd22, 1, 0);
    for (int i = 0; i < 64 && !cnvst; i++) step(1, 0, '0, 0, 0);
    repeat (3) step(1, 0, '0, 0, 0);
    check("pre_rst_cnvst", 32'(cnvst), 32'd1);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    @(negedge clk); #2;
    rst = 1'b0; enable = 0;
    #1;
    check("async_cnvst", 32'(cnvst), 32'd0);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_valid", 32'(dout_valid), 32'd0);
    check("async_dout", 32'(dout), 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    rise_q.delete();
    step(1, 0, '0, 0, 0);
    check("post_rst_start", 32'(rise_q.size()), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++)
      step(($urandom % 8) != 0, ($urandom % 12) == 0, 10'($urandom),
           ($urandom % 3) == 0, ($urandom % 40) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_conv_sequencer.md
SAR_CONV_SEQUENCER -- requirements
Module: sar_conv_sequencer

Interface
REQ-001 Parameter PERIOD, default 32, is the cycles from one conversion start to the next; it SHALL satisfy PERIOD >= TIMEOUT+2.
REQ-002 Parameter TIMEOUT, default 24, is the maximum cycles cnvst stays high awaiting eoc.
REQ-003 Parameter DEPTH, fixed at 4, is the result FIFO depth.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  high requests continuous periodic conversions.
REQ-007 eoc  input  1  end-of-conversion from SAR logic.
REQ-008 sar  input  10  SAR result, valid while eoc=1.
REQ-009 cnvst  output  1  conversion start to SAR logic, level, registered.
REQ-010 dout  output  10  FIFO head data.
REQ-011 dout_valid  output  1  FIFO non-empty.
REQ-012 dout_ready  input  1  consumer accepts head when dout_valid=1.
REQ-013 fifo_count  output  3  entries held, 0..4.
REQ-014 overflow  output  1  sticky: a result was dropped because the FIFO was full.
REQ-015 timeout_err  output  1  sticky: a conversion timed out.
REQ-016 clr_err  input  1  synchronous clear of both sticky flags.

Function
REQ-017 The FSM SHALL have the states IDLE, CONV and GAP, and cnvst SHALL be 1 exactly when the state is CONV.
REQ-018 IDLE -> CONV: on the edge where enable=1 is sampled; cnvst rises one cycle after that enable sample.
REQ-019 On CONV entry, a start counter SHALL reset to 0 and then increment every cycle until the next CONV entry.
REQ-020 CONV -> GAP (capture): when eoc=1 is sampled, sar is pushed into the FIFO on that edge and cnvst falls on the same edge.
REQ-021 CONV -> GAP (timeout): when start counter = TIMEOUT-1 and eoc=0, timeout_err is set, nothing is pushed, and cnvst falls.
REQ-022 enable changes during CONV are ignored, so an in-flight conversion always completes or times out.
REQ-023 GAP exit: when start counter = PERIOD-1 and eoc=0, go to CONV if enable=1, else to IDLE.
REQ-024 If eoc is still 1 when start counter = PERIOD-1, the FSM SHALL hold in GAP until eoc=0, then exit per REQ-023; the start counter saturates at PERIOD-1.
REQ-025 With enable held high and eoc returning before the timeout, consecutive cnvst rising edges are exactly PERIOD cycles apart.
REQ-026 FIFO pop occurs when dout_valid=1 and dout_ready=1; dout_ready is ignored when the FIFO is empty.
REQ-027 Push when fifo_count<4: the entry is stored and fifo_count increments, unless a pop occurs in the same cycle, in which case the count is unchanged.
REQ-028 Push when fifo_count=4 with a simultaneous pop: the push is accepted, the count stays 4, and overflow is not set.
REQ-029 Push when fifo_count=4 without a pop: the new sample is dropped, the stored data is unchanged, and overflow is set.
REQ-030 dout SHALL be the oldest entry, in order; its value is don't-care when dout_valid=0; read and write pointers wrap modulo 4.
REQ-031 clr_err=1 clears overflow and timeout_err on the next edge; if an error event occurs in the same cycle, the set wins.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, cnvst=0, fifo_count=0, dout_valid=0, dout=0, overflow=0, timeout_err=0, pointers=0 and start counter=0.
REQ-033 A reset asserted mid-CONV SHALL drop cnvst asynchronously, and the pending sample is lost.
REQ-034 After rst rises, the first CONV entry SHALL occur on the first edge with enable=1.

Verification
REQ-035 enable=1 with eoc pulsed 1 cycle and sar=10'h2A5 on the 12th cnvst-high cycle -> cnvst high for exactly 12 cycles, fifo_count=1, dout=10'h2A5, next cnvst rise 32 cycles after the first.
REQ-036 eoc held 0 -> cnvst high for exactly 24 cycles, timeout_err=1, fifo_count=0, next start 32 cycles after the previous one; then clr_err=1 -> timeout_err=0.
REQ-037 dout_ready=0 and 5 conversions with sar=1..5 -> fifo_count=4, overflow=1, and draining yields 1,2,3,4.
REQ-038 FIFO full, dout_ready=1 in the same cycle as an eoc capture with sar=9 -> fifo_count stays 4, overflow=0, and the last drained value is 9.
REQ-039 rst=0 pulsed mid-CONV with fifo_count=2 -> cnvst=0 and fifo_count=0 without waiting for a clock edge; after release with enable=1, cnvst rises one cycle after the first enable sample.
REQ-040 enable dropped mid-CONV -> the conversion completes and is captured, then the FSM is in IDLE after the GAP with no further cnvst.
